// File: rtl/ethernet_sys_pio_out_pkg.sv
// ethernet_sys_pio_out_pkg
// Shared definitions for the ethernet_sys output PIO. It holds the Avalon
// word offsets of each register, the STATUS bit positions and the encoding
// of the one-shot pulse engine state.
package ethernet_sys_pio_out_pkg;

  // Avalon word addresses. Offsets 6 and 7 are reserved.
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_PULSE     = 3'd2;
  localparam logic [2:0] ADDR_STATUS    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  // Bit positions inside the STATUS word.
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_OVERRUN_BIT = 1;

  // Pulse engine states.
  typedef enum logic {
    PT_IDLE  = 1'b0,
    PT_PULSE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/ethernet_sys_pio_out_pulse_timer.sv
// ethernet_sys_pio_out_pulse_timer
// One-shot pulse engine. A start request with a nonzero mask in IDLE loads
// the mask and a down-counter. The mask is then held for max(len,1) clocks
// and cleared. A start request that arrives while a pulse is running is
// dropped and flagged on start_rejected for that cycle.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   start          one-cycle request (a bus write to PULSE)
//   len            programmed pulse length in clocks (0 is treated as 1)
//   mask           bits to invert for the duration of the pulse
//   pulse_mask     mask currently being applied (0 when idle)
//   busy           high while a pulse is running
//   start_rejected high when start arrives while a pulse is running
module ethernet_sys_pio_out_pulse_timer
  import ethernet_sys_pio_out_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] mask,
  output logic [DATA_WIDTH-1:0] pulse_mask,
  output logic                  busy,
  output logic                  start_rejected
);

  pulse_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PT_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  // The counter holds the number of edges remaining after the current one.
  // Loading max(len,1)-1 therefore keeps the mask up for exactly
  // max(len,1) clocks.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mask_d         = mask_q;
    start_rejected = 1'b0;
    case (state_q)
      PT_IDLE: begin
        if (start && (mask != '0)) begin
          state_d = PT_PULSE;
          mask_d  = mask;
          cnt_d   = (len == '0) ? '0 : (len - CNT_WIDTH'(1));
        end
      end
      PT_PULSE: begin
        // This includes a request on the final edge of a pulse.
        if (start) begin
          start_rejected = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = PT_IDLE;
          mask_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = PT_IDLE;
        mask_d  = '0;
      end
    endcase
  end

  assign pulse_mask = mask_q;
  assign busy       = (state_q == PT_PULSE);

endmodule

// File: rtl/ethernet_sys_pio_out.sv
// ethernet_sys_pio_out
// Avalon-MM slave output PIO with a data register, atomic set/clear and a
// hardware one-shot pulse engine. The output pins show data_reg XOR the
// active pulse mask.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    Avalon word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data; bits above the register width are ignored
//   readdata   registered, zero-extended read data (1 clock latency)
//   out_port   output pins
module ethernet_sys_pio_out
  import ethernet_sys_pio_out_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int                    PULSE_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam int USED_W = (DATA_WIDTH > PULSE_CNT_WIDTH) ? DATA_WIDTH : PULSE_CNT_WIDTH;

  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [PULSE_CNT_WIDTH-1:0] pulse_len_q, pulse_len_d;
  logic                       overrun_q, overrun_d;
  logic [31:0]                readdata_q, readdata_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic                  pulse_start;
  logic [DATA_WIDTH-1:0] pulse_mask;
  logic                  busy;
  logic                  start_rejected;
  logic                  unused_wd_hi;

  assign wr_en        = chipselect && !write_n;
  assign wd           = writedata[DATA_WIDTH-1:0];
  assign pulse_start  = wr_en && (address == ADDR_PULSE);
  assign unused_wd_hi = ^writedata[31:USED_W];

  ethernet_sys_pio_out_pulse_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (PULSE_CNT_WIDTH)
  ) u_pulse_timer (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (pulse_start),
    .len            (pulse_len_q),
    .mask           (wd),
    .pulse_mask     (pulse_mask),
    .busy           (busy),
    .start_rejected (start_rejected)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q      <= RESET_VALUE;
      pulse_len_q <= '0;
      overrun_q   <= 1'b0;
      readdata_q  <= '0;
    end else begin
      data_q      <= data_d;
      pulse_len_q <= pulse_len_d;
      overrun_q   <= overrun_d;
      readdata_q  <= readdata_d;
    end
  end

  // Register writes. OUTSET and OUTCLEAR modify data_reg in place so that
  // software can change single lines without a read-modify-write.
  always_comb begin
    data_d      = data_q;
    pulse_len_d = pulse_len_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:      data_d      = wd;
        ADDR_PULSE_LEN: pulse_len_d = writedata[PULSE_CNT_WIDTH-1:0];
        ADDR_OUTSET:    data_d      = data_q | wd;
        ADDR_OUTCLEAR:  data_d      = data_q & ~wd;
        default:        ;
      endcase
    end
  end

  // The set is applied after the clear, so a rejected start on the same
  // edge as a STATUS write leaves overrun set.
  always_comb begin
    overrun_d = overrun_q;
    if (wr_en && (address == ADDR_STATUS)) begin
      overrun_d = 1'b0;
    end
    if (start_rejected) begin
      overrun_d = 1'b1;
    end
  end

  // Read mux. It runs every clock regardless of chipselect and samples the
  // state before any same-edge write.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:      readdata_d[DATA_WIDTH-1:0]      = data_q;
      ADDR_PULSE_LEN: readdata_d[PULSE_CNT_WIDTH-1:0] = pulse_len_q;
      ADDR_PULSE:     readdata_d[DATA_WIDTH-1:0]      = pulse_mask;
      ADDR_STATUS: begin
        readdata_d[STATUS_BUSY_BIT]    = busy;
        readdata_d[STATUS_OVERRUN_BIT] = overrun_q;
      end
      default:        readdata_d = '0;
    endcase
  end

  assign readdata = readdata_q;
  assign out_port = data_q ^ pulse_mask;

endmodule

// File: tb/tb_ethernet_sys_pio_out.sv
// tb_ethernet_sys_pio_out
// Directed bench for the output PIO. The stimulus process drives one bus
// cycle per call and pushes the hand-computed responses it expects into a
// scoreboard, each tagged with the cycle it is due. A separate monitor
// samples the DUT on every falling edge and retires the entries due then.
module tb_ethernet_sys_pio_out;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } sb_entry_t;

  localparam int KIND_OUT = 0;
  localparam int KIND_RD  = 1;

  sb_entry_t sbQ[$];
  sb_entry_t curEntry;
  logic [31:0] actual;
  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  ethernet_sys_pio_out #(
    .DATA_WIDTH      (8),
    .RESET_VALUE     (8'hA5),
    .PULSE_CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // Free-running clock and an edge counter used to time-stamp expectations.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: on each falling edge, retire every entry due now. An entry
  // found with a due cycle already in the past counts as a failure.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
      curEntry = sbQ.pop_front();
      actual   = (curEntry.kind == KIND_OUT) ? {24'b0, out_port} : readdata;
      checks++;
      if (curEntry.due == cyc && actual === curEntry.exp) begin
        passes++;
      end else begin
        $display("[TB] FAIL %s: got %h, expected %h (due cycle %0d, now %0d)",
                 curEntry.name, actual, curEntry.exp, curEntry.due, cyc);
      end
    end
  end

  // Drive one bus cycle. The values are sampled by the next rising edge.
  task automatic applyStimulus(input logic cs, input logic wr,
                               input logic [2:0] addr, input logic [31:0] wd);
    @(negedge clk);
    #1;
    chipselect = cs;
    write_n    = ~wr;
    address    = addr;
    writedata  = wd;
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [31:0] wd);
    applyStimulus(1'b1, 1'b1, addr, wd);
  endtask

  task automatic readReg(input logic [2:0] addr);
    applyStimulus(1'b0, 1'b0, addr, 32'h0);
  endtask

  // Queue an expectation d cycles after the edge that samples the bus
  // cycle just driven. The queue is kept ordered by due cycle.
  task automatic checkOutput(input int kind, input int d,
                             input logic [31:0] exp, input string name);
    sb_entry_t e;
    int pos;
    e.due  = cyc + 1 + d;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    pos = sbQ.size();
    while (pos > 0 && sbQ[pos-1].due > e.due) pos--;
    sbQ.insert(pos, e);
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'h0;

    // Reset state and readback of every readable register.
    readReg(3'd0);
    checkOutput(KIND_OUT, 0, 32'hA5, "reset_out_port");
    checkOutput(KIND_RD,  0, 32'h0,  "reset_readdata");
    readReg(3'd0);
    reset_n = 1'b1;
    checkOutput(KIND_RD,  0, 32'hA5, "rd_data_reset");
    checkOutput(KIND_OUT, 0, 32'hA5, "out_after_release");
    readReg(3'd1); checkOutput(KIND_RD, 0, 32'h0, "rd_len_reset");
    readReg(3'd2); checkOutput(KIND_RD, 0, 32'h0, "rd_pulse_reset");
    readReg(3'd3); checkOutput(KIND_RD, 0, 32'h0, "rd_status_reset");
    readReg(3'd4); checkOutput(KIND_RD, 0, 32'h0, "rd_outset_zero");
    readReg(3'd6); checkOutput(KIND_RD, 0, 32'h0, "rd_reserved_zero");

    // DATA write; the same-cycle read still shows the old value.
    writeReg(3'd0, 32'hFFFF_FF3C);
    checkOutput(KIND_RD,  0, 32'hA5, "rd_before_write");
    checkOutput(KIND_OUT, 0, 32'h3C, "out_data_3c");
    readReg(3'd0);
    checkOutput(KIND_RD,  0, 32'h3C, "rd_data_3c");

    // Atomic set and clear.
    writeReg(3'd0, 32'h0F); checkOutput(KIND_OUT, 0, 32'h0F, "out_data_0f");
    writeReg(3'd4, 32'hF0); checkOutput(KIND_OUT, 0, 32'hFF, "out_outset");
    checkOutput(KIND_RD, 0, 32'h0, "rd_outset_wo");
    writeReg(3'd5, 32'h03); checkOutput(KIND_OUT, 0, 32'hFC, "out_outclear");
    checkOutput(KIND_RD, 0, 32'h0, "rd_outclear_wo");
    readReg(3'd5);          checkOutput(KIND_RD, 0, 32'h0, "rd_outclear_after");

    // Five-clock pulse of 0x81 over DATA=0.
    writeReg(3'd1, 32'd5);
    writeReg(3'd0, 32'h00); checkOutput(KIND_OUT, 0, 32'h00, "out_data_00");
    writeReg(3'd2, 32'h81);
    for (int k = 0; k < 5; k++) checkOutput(KIND_OUT, k, 32'h81, "out_pulse5_on");
    checkOutput(KIND_OUT, 5, 32'h00, "out_pulse5_off");
    for (int i = 1; i <= 6; i++) begin
      readReg((i == 1) ? 3'd2 : 3'd3);
      checkOutput(KIND_RD, 0, (i == 1) ? 32'h81 : ((i <= 5) ? 32'h1 : 32'h0),
                  "rd_pulse5_status");
    end

    // Zero length behaves as one clock; a zero mask does nothing.
    writeReg(3'd1, 32'd0);
    writeReg(3'd2, 32'h01);
    checkOutput(KIND_OUT, 0, 32'h01, "out_len0_on");
    checkOutput(KIND_OUT, 1, 32'h00, "out_len0_off");
    readReg(3'd3); checkOutput(KIND_RD, 0, 32'h1, "rd_len0_busy");
    readReg(3'd3); checkOutput(KIND_RD, 0, 32'h0, "rd_len0_idle");
    writeReg(3'd2, 32'h00); checkOutput(KIND_OUT, 0, 32'h00, "out_mask0");
    readReg(3'd3); checkOutput(KIND_RD, 0, 32'h0, "rd_mask0_status");
    readReg(3'd2); checkOutput(KIND_RD, 0, 32'h0, "rd_mask0_pulse");

    // Ten-clock pulse with overrun, STATUS clear, a DATA write under the
    // pulse and a dropped request on the final edge.
    writeReg(3'd1, 32'd10);
    writeReg(3'd2, 32'h01);
    for (int k = 0; k < 3; k++)  checkOutput(KIND_OUT, k, 32'h01, "out_p10_on");
    for (int k = 3; k < 10; k++) checkOutput(KIND_OUT, k, 32'h00, "out_p10_xor");
    checkOutput(KIND_OUT, 10, 32'h01, "out_p10_end");
    checkOutput(KIND_OUT, 11, 32'h01, "out_p10_no_restart");
    writeReg(3'd2, 32'h02);
    readReg(3'd3);          checkOutput(KIND_RD, 0, 32'h3, "rd_overrun");
    writeReg(3'd0, 32'h01);
    writeReg(3'd3, 32'h00); checkOutput(KIND_RD, 0, 32'h3, "rd_status_prewrite");
    readReg(3'd3);          checkOutput(KIND_RD, 0, 32'h1, "rd_overrun_cleared");
    for (int i = 0; i < 4; i++) readReg(3'd3);
    writeReg(3'd2, 32'h04); checkOutput(KIND_RD, 0, 32'h1, "rd_last_busy");
    readReg(3'd3);          checkOutput(KIND_RD, 0, 32'h2, "rd_final_edge_overrun");
    writeReg(3'd3, 32'h00);
    readReg(3'd3);          checkOutput(KIND_RD, 0, 32'h0, "rd_status_clear");
    readReg(3'd2);          checkOutput(KIND_RD, 0, 32'h0, "rd_pulse_idle");

    // Reset in the middle of an eight-clock pulse.
    writeReg(3'd1, 32'd8);
    writeReg(3'd2, 32'h10);
    for (int k = 0; k < 3; k++) checkOutput(KIND_OUT, k, 32'h11, "out_p8_on");
    readReg(3'd0);
    readReg(3'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    checkOutput(KIND_OUT, 0, 32'hA5, "out_reset_abort");
    checkOutput(KIND_RD,  0, 32'h0,  "rd_reset_abort");
    readReg(3'd3);
    reset_n = 1'b1;
    checkOutput(KIND_RD, 0, 32'h0, "rd_status_after_reset");
    writeReg(3'd1, 32'd8);
    writeReg(3'd2, 32'h10);
    for (int k = 0; k < 8; k++) checkOutput(KIND_OUT, k, 32'hB5, "out_p8_again_on");
    checkOutput(KIND_OUT, 8, 32'hA5, "out_p8_again_off");
    readReg(3'd2); checkOutput(KIND_RD, 0, 32'h10, "rd_p8_mask");
    readReg(3'd0);

    // Let the monitor drain the remaining expectations, with a bound.
    begin
      int guard = 0;
      while (sbQ.size() > 0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (sbQ.size() > 0) begin
        checks++;
        $display("[TB] FAIL drain: %0d expectations left, required 0", sbQ.size());
      end
    end
    @(negedge clk);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ethernet_sys_pio_out.md
# ethernet_sys_pio_out

Avalon-MM slave output PIO for the ethernet_sys Qsys system: the write-side counterpart to the system's input PIO. The Nios II master drives board-level control lines such as PHY reset, LEDs and strobes through it. It provides a data register, atomic bit set/clear, and a hardware one-shot pulse engine. The engine inverts selected bits for a programmed number of clocks, so software can generate timed strobes without busy-waiting.

## Interface
- DATA_WIDTH, 8, width of out_port and of all data/mask registers
- RESET_VALUE, 8'h00, value loaded into the data register by reset
- PULSE_CNT_WIDTH, 16, width of the pulse-length register and down-counter
- clk  in  1  system clock; the block has this one clock only
- reset_n  in  1  reset, asynchronous assert, active-low
- address  in  3  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0
- writedata  in  32  write data; bits above the register width are ignored
- readdata  out  32  registered read data, zero-extended
- out_port  out  DATA_WIDTH  output pins, equal to data_reg XOR pulse_mask

## Operation
- Register map (word addresses):
  - 0 DATA: R/W, data_reg.
  - 1 PULSE_LEN: R/W, pulse_len[PULSE_CNT_WIDTH-1:0].
  - 2 PULSE: write = pulse mask; read = currently active pulse_mask.
  - 3 STATUS: read bit0=busy, bit1=overrun; any write clears overrun.
  - 4 OUTSET: write-only, data_reg |= wd.
  - 5 OUTCLEAR: write-only, data_reg &= ~wd.
  - 6–7: reserved; read 0, writes ignored.
  - Write-only registers read 0.
- Pulse engine states:
  - IDLE: pulse_mask=0, busy=0.
  - PULSE: busy=1.
- IDLE→PULSE on a write to PULSE with a nonzero masked value:
  - pulse_mask ← wd[DATA_WIDTH-1:0].
  - cnt ← max(pulse_len,1)−1.
  - A pulse_len of 0 is treated as 1.
- A write to PULSE with mask 0 in IDLE is a no-op.
- In PULSE, at each clock edge:
  - if cnt==0: pulse_mask←0 and go to IDLE;
  - otherwise cnt←cnt−1.
- A write to PULSE while in PULSE is dropped and sets overrun. This includes the final edge of a pulse. The active pulse is unaffected.
- Writes to PULSE_LEN during a pulse affect only the next pulse.
- Writes to DATA, OUTSET and OUTCLEAR during a pulse update data_reg immediately. out_port continues to show data_reg XOR pulse_mask.
- If overrun is set and cleared on the same edge, set wins.

## Timing
- Reset values:
  - data_reg = RESET_VALUE; out_port = RESET_VALUE.
  - pulse_mask = 0; pulse_len = 0; cnt = 0; state = IDLE; overrun = 0.
  - readdata = 0.
- Writes take effect on the clock edge that samples them. out_port is a combinational XOR of two flops, so it changes immediately after that edge.
- Read latency is 1 clock. readdata updates every clock from the current address, regardless of chipselect, and reflects register state before any same-edge write.
- Pulse width: a PULSE write at edge N with effective length L makes the mask bits active from edge N to edge N+L, i.e. exactly L clocks. busy is 1 during the same window.
- Asserting reset mid-pulse aborts the pulse immediately (asynchronously); out_port returns to RESET_VALUE.

## Structure
- Package ethernet_sys_pio_out_pkg holds:
  - register offsets ADDR_DATA through ADDR_OUTCLEAR;
  - STATUS bit indices;
  - the pulse-engine state encoding.
- Sub-module ethernet_sys_pio_out_pulse_timer contains the counter and state machine:
  - inputs: start, len, mask;
  - outputs: pulse_mask, busy, start_rejected.
- The top level holds the address decode, data_reg, overrun and the readdata mux.

## Test plan
- Reset with RESET_VALUE=8'hA5 → out_port=A5 and every readable register reads back its reset value. Write DATA=0x3C → out_port=3C on the next cycle; a read of address 0 returns 0x0000003C after 1 clock.
- From DATA=0x0F: OUTSET 0xF0, then OUTCLEAR 0x03 → out_port=FF, then FC. Reads of addresses 4 and 5 return 0.
- PULSE_LEN=5, DATA=0x00, PULSE 0x81 → out_port=81 for exactly 5 clocks, then 00. STATUS reads 1 during the pulse and 0 after it.
- PULSE_LEN=0, PULSE 0x01 → out_port bit0 high for 1 clock. PULSE 0x00 → no activity.
- During a 10-cycle pulse:
  - PULSE 0x02 → dropped and STATUS=3; the pulse still ends on schedule.
  - write STATUS → STATUS=0 after the pulse ends.
  - DATA write 0x01 on pulse mask 0x01 → out_port=00 until the pulse ends, then 01.
- reset_n asserted mid-pulse at cycle 3 of 8 → out_port=RESET_VALUE immediately. After release, STATUS=0 and a new pulse runs its full length.
